// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: load/store size codes, FSM states
// and requester identifiers.
package mem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: request side builds byte enables, shifted store data and
// the misalignment flag; response side extracts and extends the loaded lane.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  req_off_i,
  input  logic [2:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  input  logic [1:0]  rsp_off_i,
  input  logic [2:0]  rsp_size_i,
  input  logic [31:0] rsp_rdata_i,
  output logic [31:0] rsp_data_o
);

  logic [31:0] rspShifted;

  // Any size code outside the byte/half encodings behaves as a full word.
  always_comb begin
    be_o       = 4'b1111;
    misalign_o = 1'b0;
    case (req_size_i)
      SZ_B, SZ_BU: be_o = 4'b0001 << req_off_i;
      SZ_H, SZ_HU: begin
        be_o       = 4'b0011 << req_off_i;
        misalign_o = req_off_i[0];
      end
      default: begin
        be_o       = 4'b1111;
        misalign_o = |req_off_i;
      end
    endcase
  end

  assign wdata_o    = req_wdata_i << {req_off_i, 3'b000};
  assign rspShifted = rsp_rdata_i >> {rsp_off_i, 3'b000};

  always_comb begin
    rsp_data_o = rspShifted;
    case (rsp_size_i)
      SZ_B:    rsp_data_o = {{24{rspShifted[7]}}, rspShifted[7:0]};
      SZ_H:    rsp_data_o = {{16{rspShifted[15]}}, rspShifted[15:0]};
      SZ_BU:   rsp_data_o = {24'd0, rspShifted[7:0]};
      SZ_HU:   rsp_data_o = {16'd0, rspShifted[15:0]};
      default: rsp_data_o = rspShifted;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto a single word-wide memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise load/store always wins.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [2:0]        ls_size,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              idleOk, grantIf, grantLs;
  logic [ADDR_W-1:0] selAddr;
  logic [2:0]        selSize;
  logic [1:0]        reqOff, rspOff;
  logic [3:0]        fmtBe;
  logic [31:0]       fmtWdata, fmtRdata;
  logic              fmtMisalign;

  assign idleOk = (state_q == IDLE) && !rst;

`ifdef MEM_ARB_RR_EN
  logic lastLs_q;

  // On a tie the requester that was not granted most recently wins.
  assign grantLs = idleOk && ls_req && !(if_req && lastLs_q);
  assign grantIf = idleOk && if_req && !(ls_req && !lastLs_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      lastLs_q <= 1'b1;
    end else if (grantIf || grantLs) begin
      lastLs_q <= grantLs;
    end
  end
`else
  assign grantLs = idleOk && ls_req;
  assign grantIf = idleOk && if_req && !ls_req;
`endif

  // Fetches are formatted as aligned full-word reads regardless of their address.
  assign selAddr = grantLs ? ls_addr : if_addr;
  assign selSize = grantLs ? ls_size : SZ_W;
  assign reqOff  = grantLs ? ls_addr[1:0] : 2'b00;
  assign rspOff  = (owner_q == REQ_LS) ? addr_q[1:0] : 2'b00;

  mem_lane_fmt u_lane_fmt (
    .req_off_i   (reqOff),
    .req_size_i  (selSize),
    .req_wdata_i (ls_wdata),
    .be_o        (fmtBe),
    .wdata_o     (fmtWdata),
    .misalign_o  (fmtMisalign),
    .rsp_off_i   (rspOff),
    .rsp_size_i  (size_q),
    .rsp_rdata_i (mem_rdata),
    .rsp_data_o  (fmtRdata)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    size_d  = size_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (grantIf || grantLs) begin
          owner_d = grantLs ? REQ_LS : REQ_IF;
          we_d    = grantLs && ls_we;
          addr_d  = selAddr;
          size_d  = selSize;
          be_d    = fmtBe;
          wdata_d = (grantLs && ls_we) ? fmtWdata : 32'd0;
          // Misaligned accesses skip memory and answer with an error directly.
          if (grantLs && fmtMisalign) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = BUSY;
            err_d   = 1'b0;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d = RESP;
          rdata_d = we_q ? 32'd0 : fmtRdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= REQ_IF;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= 3'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign if_gnt    = grantIf;
  assign ls_gnt    = grantLs;
  assign mem_req   = (state_q == BUSY);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be_q : 4'd0;
  assign mem_wdata = mem_req ? wdata_q : 32'd0;
  assign if_rvalid = (state_q == RESP) && (owner_q == REQ_IF);
  assign ls_rvalid = (state_q == RESP) && (owner_q == REQ_LS);
  assign if_rdata  = if_rvalid ? rdata_q : 32'd0;
  assign ls_rdata  = ls_rvalid ? rdata_q : 32'd0;
  assign ls_err    = ls_rvalid && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected memory-side
// and response-side records; independent monitors pop and compare them.
module tb_mem_arbiter;
  import mem_pkg::*;

  typedef struct {
    bit          isLs;
    logic [31:0] rdata;
    bit          err;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } macc_t;

  logic        clk, rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [2:0]  ls_size;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  resp_t respQ[$];
  macc_t memQ[$];
  resp_t respCur;
  macc_t memCur;

  int          checkCount = 0;
  int          passCount = 0;
  int          cycleCnt = 0;
  int          lastRvalidCycle = 0;
  int          memDelay = 0;
  int          memCnt = 0;
  logic [31:0] memData = 32'd0;
  bit          memSeen = 0;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_size   (ls_size),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .ls_err    (ls_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Memory model: raises mem_ready after memDelay cycles of mem_req.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (memCnt >= memDelay) begin
          mem_ready = 1'b1;
          mem_rdata = memData;
        end else begin
          mem_ready = 1'b0;
          memCnt++;
        end
      end else begin
        mem_ready = 1'b0;
        memCnt = 0;
      end
    end
  end

  // Memory-side monitor: checks the first cycle of each access.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && !memSeen) begin
        memSeen = 1;
        if (memQ.size() == 0) begin
          checkOutput("unexpectedMemReq", 64'd1, 64'd0);
        end else begin
          memCur = memQ.pop_front();
          checkOutput("memCtl", {mem_we, mem_be, mem_addr}, {memCur.we, memCur.be, memCur.addr});
          checkOutput("memWdata", mem_wdata, memCur.wdata);
        end
      end else if (!mem_req) begin
        memSeen = 0;
      end
    end
  end

  // Response-side monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (if_rvalid || ls_rvalid) begin
        lastRvalidCycle = cycleCnt;
        if (if_rvalid && ls_rvalid) begin
          checkOutput("dualRvalid", 64'd1, 64'd0);
        end else if (respQ.size() == 0) begin
          checkOutput("unexpectedRvalid", {ls_rvalid, if_rvalid}, 64'd0);
        end else begin
          respCur = respQ.pop_front();
          checkOutput("respOwner", ls_rvalid, respCur.isLs);
          checkOutput("respData", ls_rvalid ? ls_rdata : if_rdata, respCur.rdata);
          checkOutput("respErr", ls_err, respCur.err);
        end
      end
    end
  end

  task automatic applyStimulus(input bit isLs, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] size, output int gntCycle);
    bit got;
    got = 0;
    gntCycle = -100;
    @(posedge clk);
    #1;
    if (isLs) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_size = size;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (isLs ? ls_gnt : if_gnt) begin
        got = 1;
        gntCycle = cycleCnt;
      end
    end
    if (!got) checkOutput("gntTimeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    ls_req = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (respQ.size() == 0 && memQ.size() == 0) done = 1;
    end
    if (!done) begin
      checkOutput("drainTimeout", 64'd0, 64'd1);
      respQ.delete();
      memQ.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic runCase(input string name, input bit isLs, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] size, input logic [31:0] memD,
                         input bit expMem, input logic [31:0] memAddr, input logic [3:0] be,
                         input logic [31:0] memW, input logic [31:0] respData, input bit err,
                         input int expLat);
    int g;
    memData = memD;
    if (expMem) memQ.push_back('{we, memAddr, be, memW});
    respQ.push_back('{isLs, respData, err});
    applyStimulus(isLs, we, addr, wdata, size, g);
    waitDrain(100);
    checkOutput({name, "Lat"}, lastRvalidCycle - g, expLat);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int g;
    logic [3:0] seq, expSeq;
    int nGnt;

    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0; ls_size = SZ_W;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstCtl", {if_gnt, ls_gnt, mem_req, mem_we, if_rvalid, ls_rvalid, ls_err}, 64'd0);
    checkOutput("rstMemAddr", {mem_be, mem_addr}, 64'd0);
    checkOutput("rstMemWdata", mem_wdata, 64'd0);
    checkOutput("rstRdata", {if_rdata, ls_rdata}, 64'd0);

    // Fetch with two wait cycles; a short ls_req pulse while busy must be ignored.
    memDelay = 2;
    memData = 32'hDEADBEEF;
    memQ.push_back('{1'b0, 32'h100, 4'b1111, 32'd0});
    respQ.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
    applyStimulus(1'b0, 1'b0, 32'h100, 32'd0, SZ_W, g);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h300; ls_size = SZ_W;
    @(negedge clk);
    checkOutput("noGntBusy", ls_gnt, 64'd0);
    @(posedge clk);
    #1;
    ls_req = 1'b0; ls_we = 1'b0;
    waitDrain(100);
    checkOutput("fetch100Lat", lastRvalidCycle - g, 64'd4);

    memDelay = 0;
    //       name       ls  we addr          wdata         size    memData       mem addr          be       memWdata      respData      err lat
    runCase("lb103",    1, 0, 32'h103, 32'h0,        SZ_B,   32'h80123456, 1, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 2);
    runCase("lbu103",   1, 0, 32'h103, 32'h0,        SZ_BU,  32'h80123456, 1, 32'h100, 4'b1000, 32'h0,        32'h00000080, 0, 2);
    runCase("lh102",    1, 0, 32'h102, 32'h0,        SZ_H,   32'h80123456, 1, 32'h100, 4'b1100, 32'h0,        32'hFFFF8012, 0, 2);
    runCase("lhu000",   1, 0, 32'h000, 32'h0,        SZ_HU,  32'h1234F00D, 1, 32'h000, 4'b0011, 32'h0,        32'h0000F00D, 0, 2);
    runCase("lw104",    1, 0, 32'h104, 32'h0,        SZ_W,   32'h12345678, 1, 32'h104, 4'b1111, 32'h0,        32'h12345678, 0, 2);
    runCase("sh102",    1, 1, 32'h102, 32'h0000ABCD, SZ_H,   32'h55555555, 1, 32'h100, 4'b1100, 32'hABCD0000, 32'h0,        0, 2);
    runCase("sb101",    1, 1, 32'h101, 32'h000000EE, SZ_B,   32'h55555555, 1, 32'h100, 4'b0010, 32'h0000EE00, 32'h0,        0, 2);
    runCase("lw102",    1, 0, 32'h102, 32'h0,        SZ_W,   32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 1);
    runCase("lh101",    1, 0, 32'h101, 32'h0,        SZ_H,   32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 1);
    runCase("sw101",    1, 1, 32'h101, 32'h12345678, SZ_W,   32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 1);
    runCase("sz3_101",  1, 0, 32'h101, 32'h0,        3'b011, 32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 1);
    runCase("sz3_200",  1, 0, 32'h200, 32'h0,        3'b011, 32'hA5A5A5A5, 1, 32'h200, 4'b1111, 32'h0,        32'hA5A5A5A5, 0, 2);
    runCase("fetch203", 0, 0, 32'h203, 32'h0,        SZ_W,   32'h0BADF00D, 1, 32'h200, 4'b1111, 32'h0,        32'h0BADF00D, 0, 2);

    // Reset while an access is outstanding, then a normal fetch.
    memDelay = 100;
    memQ.push_back('{1'b0, 32'h400, 4'b1111, 32'd0});
    applyStimulus(1'b0, 1'b0, 32'h400, 32'd0, SZ_W, g);
    @(negedge clk);
    checkOutput("busyReq", mem_req, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstDropReq", mem_req, 64'd0);
    repeat (5) @(negedge clk);
    memDelay = 0;
    runCase("fetch500", 0, 0, 32'h500, 32'h0, SZ_W, 32'h11223344, 1, 32'h500, 4'b1111, 32'h0, 32'h11223344, 0, 2);

    // Both requesters held: tie-break order.
    pulseReset();
`ifdef MEM_ARB_RR_EN
    expSeq = 4'b1010;
`else
    expSeq = 4'b1111;
`endif
    memData = 32'hCAFEF00D;
    for (int k = 0; k < 4; k++) begin
      if (expSeq[k]) memQ.push_back('{1'b0, 32'h200, 4'b1111, 32'd0});
      else           memQ.push_back('{1'b0, 32'h300, 4'b1111, 32'd0});
      respQ.push_back('{expSeq[k], 32'hCAFEF00D, 1'b0});
    end
    seq = 4'd0;
    nGnt = 0;
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'h300;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_size = SZ_W;
    for (int i = 0; i < 100 && nGnt < 4; i++) begin
      @(negedge clk);
      if (if_gnt && ls_gnt) checkOutput("dualGnt", 64'd1, 64'd0);
      if (if_gnt || ls_gnt) begin
        seq[nGnt] = ls_gnt;
        nGnt++;
      end
    end
    @(posedge clk);
    #1;
    if_req = 1'b0;
    ls_req = 1'b0;
    checkOutput("arbCount", nGnt, 64'd4);
    checkOutput("arbSeq", seq, expSeq);
    waitDrain(100);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
